// File: rtl/lab3a_pkg.sv
// lab3a_pkg: shared state type, BCD limit and default debounce length for the entry sequencer
package lab3a_pkg;
   typedef enum logic [1:0] {GET_A, GET_B, SHOW} entry_state_t;
   localparam logic [3:0] BCD_MAX = 4'd9;
   localparam int DEBOUNCE_DEFAULT = 500000;
   function automatic logic [2:0] state_onehot(entry_state_t s);
      return 3'b001 << s;
   endfunction
endpackage

// File: rtl/lab3a_bcd_entry_if.sv
// lab3a_bcd_entry_if: switch/key inputs and registered operand outputs of the entry sequencer
interface lab3a_bcd_entry_if;
   logic [3:0] sw;
   logic       sw_cin;
   logic       key_n;
   logic [3:0] a;
   logic [3:0] b;
   logic       cin;
   logic       valid;
   logic       err;
   logic [2:0] state_led;
   modport master (output sw, sw_cin, key_n, input a, b, cin, valid, err, state_led);
   modport slave (input sw, sw_cin, key_n, output a, b, cin, valid, err, state_led);
endinterface

// File: rtl/lab3a_debounce.sv
// lab3a_debounce: synchronizes a raw active-low key, debounces it and pulses press on each debounced fall
module lab3a_debounce
   import lab3a_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic clk,
   input  logic reset_n,
   input  logic key_n,
   output logic db_level,
   output logic press
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   logic [1:0]    sync;
   logic [CW-1:0] cnt;
   // press is registered alongside db_level so it is high exactly in the cycle db_level reads 0
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         sync     <= 2'b11;
         cnt      <= '0;
         db_level <= 1'b1;
         press    <= 1'b0;
      end else begin
         sync  <= {sync[0], key_n};
         press <= 1'b0;
         if (sync[1] == db_level) cnt <= '0;
         else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt      <= '0;
            db_level <= sync[1];
            press    <= ~sync[1];
         end else cnt <= cnt + 1'b1;
      end
endmodule

// File: rtl/lab3a_bcd_entry.sv
// lab3a_bcd_entry: walks the user through BCD digit A, then B plus carry-in, and holds the operands for the adder
module lab3a_bcd_entry
   import lab3a_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input logic clk,
   input logic reset_n,
   lab3a_bcd_entry_if.slave io
);
   logic         db_level;
   logic         press;
   logic         take;
   logic         ok;
   entry_state_t st;
   lab3a_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk), .reset_n(reset_n), .key_n(io.key_n), .db_level(db_level), .press(press)
   );
   assign take = press & ~db_level;
   assign ok   = io.sw <= BCD_MAX;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         st           <= GET_A;
         io.a         <= '0;
         io.b         <= '0;
         io.cin       <= 1'b0;
         io.valid     <= 1'b0;
         io.err       <= 1'b0;
         io.state_led <= state_onehot(GET_A);
      end else if (take)
         unique case (st)
            GET_A:
               if (ok) begin
                  io.a         <= io.sw;
                  io.err       <= 1'b0;
                  st           <= GET_B;
                  io.state_led <= state_onehot(GET_B);
               end else io.err <= 1'b1;
            GET_B:
               if (ok) begin
                  io.b         <= io.sw;
                  io.cin       <= io.sw_cin;
                  io.err       <= 1'b0;
                  io.valid     <= 1'b1;
                  st           <= SHOW;
                  io.state_led <= state_onehot(SHOW);
               end else io.err <= 1'b1;
            default: begin
               io.a         <= '0;
               io.b         <= '0;
               io.cin       <= 1'b0;
               io.err       <= 1'b0;
               io.valid     <= 1'b0;
               st           <= GET_A;
               io.state_led <= state_onehot(GET_A);
            end
         endcase
endmodule

// File: tb/tb_lab3a_bcd_entry.sv
// tb_lab3a_bcd_entry: directed and random key/switch stimulus checked every cycle against a behavioural model
module tb_lab3a_bcd_entry;
   localparam int D = 4;
   logic clk = 1'b0;
   logic reset_n = 1'b1;
   lab3a_bcd_entry_if io ();
   lab3a_bcd_entry #(.DEBOUNCE_CYCLES(D)) dut (.clk(clk), .reset_n(reset_n), .io(io.slave));
   always #5 clk = ~clk;
   int tests = 0, fails = 0;
   int cyc = 0, npress = 0, last_press_cyc = 0, c0 = 0, guard = 0;
   bit hist[$];
   bit m_db, m_press, mcin, merr;
   int st;
   logic [3:0] ma, mb;
   function automatic void m_reset();
      hist = {};
      repeat (D + 2) hist.push_back(1'b1);
      m_db = 1'b1; m_press = 1'b0; st = 0; ma = '0; mb = '0; mcin = 1'b0; merr = 1'b0;
   endfunction
   task automatic chk(string tag, logic [13:0] got, logic [13:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask
   function automatic logic [13:0] m_out();
      return {ma, mb, mcin, st == 2, merr, 3'(1 << st)};
   endfunction
   function automatic logic [13:0] d_out();
      return {io.a, io.b, io.cin, io.valid, io.err, io.state_led};
   endfunction
   // db flips once the last D synchronized samples (raw delayed by 2) all disagree with it
   task automatic tick();
      bit all_diff;
      @(posedge clk);
      cyc++;
      if (reset_n) begin
         if (m_press) begin
            if (st == 0) begin
               if (io.sw <= 9) begin ma = io.sw; merr = 1'b0; st = 1; end else merr = 1'b1;
            end else if (st == 1) begin
               if (io.sw <= 9) begin mb = io.sw; mcin = io.sw_cin; merr = 1'b0; st = 2; end else merr = 1'b1;
            end else begin
               ma = '0; mb = '0; mcin = 1'b0; merr = 1'b0; st = 0;
            end
         end
         hist.push_back(io.key_n);
         if (hist.size() > 64) void'(hist.pop_front());
         all_diff = 1'b1;
         for (int i = 0; i < D; i++) if (hist[hist.size() - 3 - i] == m_db) all_diff = 1'b0;
         m_press = 1'b0;
         if (all_diff) begin m_db = !m_db; m_press = !m_db; end
      end
      #1;
      chk("outputs", d_out(), m_out());
      chk("press", 14'(dut.u_db.press), 14'(m_press));
      if (m_press) begin npress++; last_press_cyc = cyc; end
   endtask
   task automatic press_key(logic [3:0] s, bit c, int bounce);
      io.sw = s; io.sw_cin = c;
      repeat (bounce) begin io.key_n = 1'($urandom); tick(); end
      io.key_n = 1'b0; repeat (D + 4) tick();
      io.key_n = 1'b1; repeat (D + 4) tick();
   endtask
   initial begin
      io.key_n = 1'b1; io.sw = '0; io.sw_cin = 1'b0;
      m_reset();
      #2 reset_n = 1'b0;
      repeat (3) tick();
      chk("reset_state", d_out(), 14'b0000_0000_0_0_0_001);
      reset_n = 1'b1;
      repeat (3) tick();
      // clean press of 7
      io.sw = 4'd7; npress = 0; c0 = cyc; io.key_n = 1'b0;
      repeat (10) tick();
      chk("clean_once", 14'(npress), 14'd1);
      chk("clean_delay", 14'(last_press_cyc - c0), 14'd6);
      chk("clean_a", {io.a, io.err, io.state_led, 6'd0}, {4'd7, 1'b0, 3'b010, 6'd0});
      io.key_n = 1'b1; repeat (10) tick();
      // bouncing key offering 12 in GET_B
      io.sw = 4'd12; npress = 0;
      for (int i = 0; i < 10; i++) begin io.key_n = ~io.key_n; tick(); tick(); end
      chk("bounce_none", 14'(npress), 14'd0);
      io.key_n = 1'b0; repeat (10) tick();
      chk("bounce_once", 14'(npress), 14'd1);
      chk("getb_err", {io.err, io.state_led}, 4'b1010);
      io.key_n = 1'b1; repeat (10) tick();
      press_key(4'd5, 1'b0, 0);
      press_key(4'd0, 1'b0, 0);
      chk("back_to_a", d_out(), 14'b0000_0000_0_0_0_001);
      // rejected then accepted digit A
      press_key(4'd12, 1'b0, 0);
      chk("rej_a", {io.a, io.err, io.state_led}, {4'd0, 1'b1, 3'b001});
      press_key(4'd3, 1'b0, 0);
      chk("acc_a", {io.a, io.err, io.state_led}, {4'd3, 1'b0, 3'b010});
      press_key(4'd8, 1'b1, 0);
      press_key(4'd0, 1'b0, 0);
      // full entry 9 + 8 + 1
      press_key(4'd9, 1'b0, 3);
      press_key(4'd8, 1'b1, 3);
      chk("show", d_out(), {4'd9, 4'd8, 1'b1, 1'b1, 1'b0, 3'b100});
      press_key(4'd6, 1'b0, 0);
      chk("show_clear", d_out(), 14'b0000_0000_0_0_0_001);
      // async reset in GET_B during a debounce, key held through release
      press_key(4'd4, 1'b0, 0);
      io.sw = 4'd2; io.key_n = 1'b0; repeat (4) tick();
      #3 reset_n = 1'b0; #1;
      m_reset();
      chk("async_rst", d_out(), 14'b0000_0000_0_0_0_001);
      repeat (3) tick();
      reset_n = 1'b1; npress = 0; c0 = cyc;
      repeat (5) tick();
      chk("rst_no_early", 14'(npress), 14'd0);
      repeat (4) tick();
      chk("rst_fresh", 14'(last_press_cyc - c0), 14'd6);
      chk("rst_a", {io.a, io.state_led}, {4'd2, 3'b010});
      io.key_n = 1'b1; repeat (10) tick();
      // switch moves during the press cycle
      io.sw = 4'd2; io.sw_cin = 1'b0; io.key_n = 1'b0; guard = 0;
      do begin tick(); guard++; end while (!m_press && guard < 20);
      chk("press_seen", 14'(m_press), 14'd1);
      io.sw = 4'd5;
      tick();
      chk("sw_edge", {io.b, io.state_led}, {4'd5, 3'b100});
      io.key_n = 1'b1; repeat (10) tick();
      // random entries with random pre-press bounce
      for (int n = 0; n < 40; n++) press_key(4'($urandom_range(0, 15)), 1'($urandom), $urandom_range(0, 6));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
